dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Data-memory stage that sits directly downstream of the pipelined datapath's memory stage.
- Consumes the M-stage address, store data, write enable and access size; returns the formatted load data to the same M-stage cycle.
- Owns the data RAM, byte-lane store logic, load sign/zero extension, misalignment trapping and access counters.
- Optionally decodes a small memory-mapped I/O window used by the bench to detect program completion.

Parameters:
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two.
- MMIO_BASE, 32'h8000_0000: MMIO window base; only bits [31:28] are decoded.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address (datapath alu_outM).
- wdata  in  32  store data (datapath write_dataM).
- we  in  1  store request (datapath mem_writeM).
- re  in  1  load request (datapath mem_to_regM).
- size  in  3  access type, funct3 encoding: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- rdata  out  32  formatted load data (datapath read_dataM).
- fault  out  1  sticky misaligned/illegal-access flag.
- fault_addr  out  32  address of the first faulting access.
- load_cnt  out  32  count of completed aligned loads.
- store_cnt  out  32  count of completed aligned stores.
- tohost_valid  out  1  one-cycle pulse on a TOHOST write.
- tohost_data  out  32  last value written to TOHOST.

Behaviour:
- Reset (sync, active-high): fault=0, fault_addr=0, load_cnt=0, store_cnt=0, tohost_valid=0, tohost_data=0, cycle counter=0. RAM contents are not cleared. A reset cycle also suppresses that cycle's write.
- Indexing: word index = addr[AW+1:2], where AW=$clog2(MEM_WORDS). Upper RAM address bits are ignored, so accesses wrap.
- Read path: combinational, zero-cycle latency; rdata is valid in the same cycle as addr/size.
  - LB/LBU: byte lane addr[1:0], sign-extended for LB, zero-extended for LBU.
  - LH/LHU: half-word lane addr[1], sign-extended for LH, zero-extended for LHU.
  - LW: full word.
  - Sizes 011, 110, 111 are illegal: rdata=0.
  - re=0: rdata still reflects the RAM word formatted per size (don't-care to the datapath).
- Write path: synchronous on rising clk when we=1, reset=0, and the access is aligned and legal.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
  - Read-during-write to the same word returns the old data; the new data is visible the next cycle.
- Alignment: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - Misaligned or illegal-size store: suppressed, no RAM change.
  - Misaligned or illegal-size load: rdata=0.
  - Checked only when we|re.
- Fault latch: on a faulting access, fault=1 from the next cycle. fault_addr captures addr only if fault was 0, so only the first fault is recorded. Both are cleared only by reset.
- Counters: load_cnt increments the cycle after an aligned, legal re=1 access; store_cnt likewise for we=1. Both are 32-bit and wrap 0xFFFF_FFFF->0.
- we=1 and re=1 in the same cycle: treated as a store only; re is ignored and only store_cnt increments.
- Faulting accesses never increment counters.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined: addresses with addr[31:28]==MMIO_BASE[31:28] go to MMIO and never to RAM. Offsets are addr[3:0]:
  - 0x0 TOHOST: SW latches tohost_data; tohost_valid=1 for exactly the next cycle. Reads return 0.
  - 0x4: read-only free-running cycle counter (cleared by reset).
  - 0x8: read-only load_cnt.
  - 0xC: read-only store_cnt.
  - Any non-word MMIO access, or a store to a read-only offset, is a fault (same latch rules) and has no side effect.
  - MMIO accesses do count in load_cnt/store_cnt when legal.
- Not defined: every address decodes to RAM with wrap; tohost_valid and tohost_data are tied to 0; no cycle counter is instantiated.

Test Plan:
- Sign/zero extension: SW 0xDEADBEEF @0x10; next cycle LB @0x13 -> rdata=0xFFFFFFDE, LBU @0x13 -> 0x000000DE, LH @0x12 -> 0xFFFFDEAD, LHU @0x10 -> 0x0000BEEF.
- Byte-lane merge: after the above, SH 0x1234 @0x12, then SB 0x55 @0x10, then LW @0x10 -> 0x1234BE55; store_cnt=3.
- Misalignment and sticky fault: SW 0xFFFFFFFF @0x21 -> word @0x20 unchanged, fault=1 next cycle, fault_addr=0x21. Then LH @0x31 -> rdata=0, fault_addr stays 0x21, load_cnt unchanged.
- Simultaneous re/we and wrap: with MEM_WORDS=1024, SW 0xA5A5A5A5 @0x1000 with re=1 -> store_cnt+1, load_cnt+0; LW @0x0 -> 0xA5A5A5A5.
- MMIO (DMEM_MMIO_EN): SW 0x1 @0x8000_0000 -> tohost_valid high for exactly one cycle, tohost_data=0x1. LW @0x8000_000C -> current store_cnt. SB @0x8000_0004 -> fault=1.
- Reset mid-operation: assert reset in the same cycle as SW 0x77 @0x40 -> no write. fault, fault_addr, counters and tohost_data read 0 next cycle. Previously written RAM @0x10 still reads back unchanged.

Source files
------------

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: byte-lane RAM, load extension, alignment faults, access counters.
// Optional MMIO window (TOHOST, cycle/load/store counters) enabled by defining DMEM_MMIO_EN.
module dmem_lsu #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [2:0]  size_i,
  output logic [31:0] rdata_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o,
  output logic [31:0] load_cnt_o,
  output logic [31:0] store_cnt_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem_q [MEM_WORDS];
  logic [AW-1:0] widx;
  logic          sz_b, sz_h, sz_w, sz_ok, misal, acc, bad;
  logic          is_mmio, mmio_bad, wr_en;
  logic [3:0]    be;
  logic [31:0]   wd, src;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic          fault_q, fault_d;
  logic [31:0]   fault_addr_q, fault_addr_d;
  logic [31:0]   load_cnt_q, load_cnt_d, store_cnt_q, store_cnt_d;
  logic          unused_ok;

  assign widx      = addr_i[AW+1:2];
  assign unused_ok = ^addr_i[31:AW+2];

  always_comb begin
    sz_b = 1'b0;
    sz_h = 1'b0;
    sz_w = 1'b0;
    case (size_i)
      3'b000, 3'b100: sz_b = 1'b1;
      3'b001, 3'b101: sz_h = 1'b1;
      3'b010:         sz_w = 1'b1;
      default:        ;
    endcase
  end

  assign sz_ok = sz_b | sz_h | sz_w;
  assign misal = (sz_h & addr_i[0]) | (sz_w & (addr_i[1:0] != 2'b00));
  assign acc   = we_i | re_i;
  assign bad   = acc & (~sz_ok | misal | mmio_bad);

`ifdef DMEM_MMIO_EN
  logic        tohost_valid_q, tohost_valid_d;
  logic [31:0] tohost_data_q, tohost_data_d;
  logic [31:0] cyc_q;

  assign is_mmio  = (addr_i[31:28] == MMIO_BASE[31:28]);
  // Only word accesses are legal in the window, and only TOHOST is writable.
  assign mmio_bad = is_mmio & (~sz_w | (we_i & (addr_i[3:0] != 4'h0)));

  always_comb begin
    src = mem_q[widx];
    if (is_mmio) begin
      case (addr_i[3:2])
        2'd0:    src = 32'h0;
        2'd1:    src = cyc_q;
        2'd2:    src = load_cnt_q;
        default: src = store_cnt_q;
      endcase
    end
  end

  assign tohost_valid_d = we_i & ~bad & is_mmio & (addr_i[3:0] == 4'h0);
  assign tohost_data_d  = tohost_valid_d ? wdata_i : tohost_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= 32'h0;
      cyc_q          <= 32'h0;
    end else begin
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
      cyc_q          <= cyc_q + 32'd1;
    end
  end

  assign tohost_valid_o = tohost_valid_q;
  assign tohost_data_o  = tohost_data_q;
`else
  assign is_mmio        = 1'b0;
  assign mmio_bad       = 1'b0;
  assign src            = mem_q[widx];
  assign tohost_valid_o = 1'b0;
  assign tohost_data_o  = 32'h0;
`endif

  // Load formatting; illegal sizes and faulting accesses return zero.
  assign rbyte = src[{addr_i[1:0], 3'b000} +: 8];
  assign rhalf = addr_i[1] ? src[31:16] : src[15:0];

  always_comb begin
    rdata_o = 32'h0;
    case (size_i)
      3'b000:  rdata_o = {{24{rbyte[7]}}, rbyte};
      3'b100:  rdata_o = {24'h0, rbyte};
      3'b001:  rdata_o = {{16{rhalf[15]}}, rhalf};
      3'b101:  rdata_o = {16'h0, rhalf};
      3'b010:  rdata_o = src;
      default: rdata_o = 32'h0;
    endcase
    if (bad) rdata_o = 32'h0;
  end

  always_comb begin
    be = 4'b1111;
    wd = wdata_i;
    if (sz_b) begin
      be = 4'b0001 << addr_i[1:0];
      wd = {4{wdata_i[7:0]}};
    end else if (sz_h) begin
      be = addr_i[1] ? 4'b1100 : 4'b0011;
      wd = {2{wdata_i[15:0]}};
    end
  end

  assign wr_en = we_i & ~reset_i & ~bad & ~is_mmio;

  // RAM is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  // A simultaneous load+store is a store only.
  assign load_cnt_d   = load_cnt_q + {31'h0, re_i & ~we_i & ~bad};
  assign store_cnt_d  = store_cnt_q + {31'h0, we_i & ~bad};
  assign fault_d      = fault_q | bad;
  assign fault_addr_d = (bad & ~fault_q) ? addr_i : fault_addr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      load_cnt_q   <= 32'h0;
      store_cnt_q  <= 32'h0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
    end
  end

  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;
  assign load_cnt_o   = load_cnt_q;
  assign store_cnt_o  = store_cnt_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu; MMIO checks compile in when DMEM_MMIO_EN is defined.
module tb_dmem_lsu;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] addr_i, wdata_i;
  logic        we_i, re_i;
  logic [2:0]  size_i;
  logic [31:0] rdata_o, fault_addr_o, load_cnt_o, store_cnt_o, tohost_data_o;
  logic        fault_o, tohost_valid_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_ld, exp_st;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  dmem_lsu dut (
    .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .we_i(we_i), .re_i(re_i), .size_i(size_i), .rdata_o(rdata_o),
    .fault_o(fault_o), .fault_addr_o(fault_addr_o), .load_cnt_o(load_cnt_o),
    .store_cnt_o(store_cnt_o), .tohost_valid_o(tohost_valid_o),
    .tohost_data_o(tohost_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive one access, then settle so combinational rdata can be sampled before the edge.
  task automatic drv(input logic w, input logic r, input logic [2:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    we_i = w; re_i = r; size_i = s; addr_i = a; wdata_i = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    we_i = 1'b0; re_i = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [2:0] s, input logic [31:0] a,
                    input logic [31:0] exp);
    drv(1'b0, 1'b1, s, a, 32'h0);
    chk(tag, rdata_o, exp);
    step();
    exp_ld++;
  endtask

  task automatic st(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    drv(1'b1, 1'b0, s, a, d);
    step();
    exp_st++;
  endtask

  initial begin
    reset_i = 1'b1; we_i = 1'b0; re_i = 1'b0; size_i = LW; addr_i = 32'h0; wdata_i = 32'h0;
    exp_ld = 0; exp_st = 0;
    step(); step();
    reset_i = 1'b0;
    chk("rst_fault", {31'h0, fault_o}, 32'h0);
    chk("rst_faddr", fault_addr_o, 32'h0);
    chk("rst_ldcnt", load_cnt_o, 32'h0);
    chk("rst_stcnt", store_cnt_o, 32'h0);
    chk("rst_thdata", tohost_data_o, 32'h0);
    chk("rst_thvalid", {31'h0, tohost_valid_o}, 32'h0);

    // Extension
    st(LW, 32'h10, 32'hDEAD_BEEF);
    ld("lb_13", LB, 32'h13, 32'hFFFF_FFDE);
    ld("lbu_13", LBU, 32'h13, 32'h0000_00DE);
    ld("lh_12", LH, 32'h12, 32'hFFFF_DEAD);
    ld("lhu_10", LHU, 32'h10, 32'h0000_BEEF);
    ld("lb_11", LB, 32'h11, 32'hFFFF_FFBE);
    chk("ldcnt_ext", load_cnt_o, exp_ld);

    // Byte-lane merge
    st(LH, 32'h12, 32'h0000_1234);
    st(LB, 32'h10, 32'h0000_0055);
    chk("stcnt_merge", store_cnt_o, 32'd3);
    ld("lw_merge", LW, 32'h10, 32'h1234_BE55);

    // Read-during-write returns old word, new word next cycle
    drv(1'b1, 1'b0, LW, 32'h10, 32'h0BAD_F00D);
    chk("rdw_old", rdata_o, 32'h1234_BE55);
    step(); exp_st++;
    ld("rdw_new", LW, 32'h10, 32'h0BAD_F00D);

    // Misalignment and sticky fault
    st(LW, 32'h20, 32'h600D_CAFE);
    drv(1'b1, 1'b0, LW, 32'h21, 32'hFFFF_FFFF);
    step();
    chk("mis_fault", {31'h0, fault_o}, 32'h1);
    chk("mis_faddr", fault_addr_o, 32'h21);
    chk("mis_stcnt", store_cnt_o, exp_st);
    ld("mis_nowrite", LW, 32'h20, 32'h600D_CAFE);
    drv(1'b0, 1'b1, LH, 32'h31, 32'h0);
    chk("mis_lh_rdata", rdata_o, 32'h0);
    step();
    chk("mis_faddr_sticky", fault_addr_o, 32'h21);
    chk("mis_ldcnt", load_cnt_o, exp_ld);
    drv(1'b0, 1'b1, 3'b011, 32'h20, 32'h0);
    chk("ill_rdata", rdata_o, 32'h0);
    step();
    chk("ill_ldcnt", load_cnt_o, exp_ld);

    // Simultaneous re/we is a store; address wraps
    drv(1'b1, 1'b1, LW, 32'h1000, 32'hA5A5_A5A5);
    step(); exp_st++;
    chk("rw_stcnt", store_cnt_o, exp_st);
    chk("rw_ldcnt", load_cnt_o, exp_ld);
    ld("wrap_lw", LW, 32'h0, 32'hA5A5_A5A5);

`ifdef DMEM_MMIO_EN
    st(LW, 32'h8000_0000, 32'h1);
    chk("th_valid", {31'h0, tohost_valid_o}, 32'h1);
    chk("th_data", tohost_data_o, 32'h1);
    step();
    chk("th_valid_pulse", {31'h0, tohost_valid_o}, 32'h0);
    ld("mmio_stcnt", LW, 32'h8000_000C, exp_st);
    ld("mmio_ldcnt", LW, 32'h8000_0008, exp_ld);
    drv(1'b1, 1'b0, LB, 32'h8000_0004, 32'h5);
    step();
    chk("mmio_sb_fault", {31'h0, fault_o}, 32'h1);
    chk("mmio_sb_stcnt", store_cnt_o, exp_st);
`else
    st(LW, 32'h8000_0000, 32'h1);
    chk("nommio_thvalid", {31'h0, tohost_valid_o}, 32'h0);
    chk("nommio_thdata", tohost_data_o, 32'h0);
    ld("nommio_wrap", LW, 32'h0, 32'h1);
`endif

    // Reset mid-operation suppresses the write
    st(LW, 32'h40, 32'h1234_5678);
    chk("pre_rst_stcnt", store_cnt_o, exp_st);
    reset_i = 1'b1;
    drv(1'b1, 1'b0, LW, 32'h40, 32'h77);
    step();
    reset_i = 1'b0;
    chk("mid_fault", {31'h0, fault_o}, 32'h0);
    chk("mid_faddr", fault_addr_o, 32'h0);
    chk("mid_ldcnt", load_cnt_o, 32'h0);
    chk("mid_stcnt", store_cnt_o, 32'h0);
    chk("mid_thdata", tohost_data_o, 32'h0);
    ld("mid_nowrite", LW, 32'h40, 32'h1234_5678);
    ld("mid_keep", LW, 32'h10, 32'h0BAD_F00D);
    chk("post_ldcnt", load_cnt_o, 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
